// File: rtl/xadc_ovs_pkg.sv
// Shared definitions for the multi-channel XADC oversampler: derived widths,
// rounding helper and the XADC channel tags used by the sequencer readout.
package xadc_ovs_pkg;

  // XADC DRP channel tags (channel_out encoding)
  typedef enum logic [4:0] {
    XADC_TEMP   = 5'h00,
    XADC_VCCINT = 5'h01,
    XADC_VCCAUX = 5'h02,
    XADC_VP_VN  = 5'h03,
    VAUX0       = 5'h10,
    VAUX1       = 5'h11,
    VAUX2       = 5'h12,
    VAUX3       = 5'h13
  } xadc_ch_e;

  // Accumulator width: a full block of 2^osr_log2 samples cannot overflow it
  function automatic int acc_w(input int in_w, input int osr_log2);
    return in_w + osr_log2;
  endfunction

  // Result width after adding extra precision bits
  function automatic int out_w(input int in_w, input int extra_bits);
    return in_w + extra_bits;
  endfunction

  // Right shift applied to the full sum to form the result
  function automatic int shift_s(input int osr_log2, input int extra_bits);
    return osr_log2 - extra_bits;
  endfunction

  // Half-LSB constant for round-half-up; zero when no shift is applied
  function automatic int unsigned round_const(input int s);
    return (s > 0) ? (32'd1 << (s - 1)) : 32'd0;
  endfunction

endpackage

// File: rtl/xadc_ovs_rr_arb.sv
// Combinational round-robin pick: lowest requesting index at or after ptr,
// wrapping around NUM_CH.
module xadc_ovs_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_idx
);

  logic [IDX_W-1:0] cand;

  // Scan candidates in rotated order starting at ptr; first hit wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_CH);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/xadc_oversampler_mc.sv
// Multi-channel XADC oversampler: per-channel accumulate of 2^OSR_LOG2
// samples, rounded result with EXTRA_BITS of added precision, round-robin
// drain through a valid/ready output slot.
// Optional: XADC_OVS_OVERRUN_STATUS_EN adds clr_overrun / sticky overrun.
module xadc_oversampler_mc
  import xadc_ovs_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 5,
  parameter int IN_W       = 12,
  parameter int OSR_LOG2   = 8,
  parameter int EXTRA_BITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [CH_W-1:0]            in_channel,
  input  logic [IN_W-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_channel,
  output logic [IN_W+EXTRA_BITS-1:0] out_data
`ifdef XADC_OVS_OVERRUN_STATUS_EN
  ,
  input  logic                       clr_overrun,
  output logic [NUM_CH-1:0]          overrun
`endif
);

  localparam int ACC_W = acc_w(IN_W, OSR_LOG2);
  localparam int OUT_W = out_w(IN_W, EXTRA_BITS);
  localparam int S     = shift_s(OSR_LOG2, EXTRA_BITS);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ACC_W-1:0] RND  = ACC_W'(round_const(S));
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

  logic [ACC_W-1:0]    acc [NUM_CH];
  logic [OSR_LOG2-1:0] cnt [NUM_CH];
  logic [OUT_W-1:0]    res [NUM_CH];
  logic [NUM_CH-1:0]   pend, pend_next;
  logic [IDX_W-1:0]    rr_ptr;

  logic                accept, done, drain, take;
  logic [IDX_W-1:0]    ch;
  logic [ACC_W-1:0]    sum_full;
  logic [OUT_W-1:0]    res_new;
  logic                gnt_valid;
  logic [IDX_W-1:0]    gnt_idx;

  xadc_ovs_rr_arb #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (pend),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Sample acceptance, block completion and rounding of the finished sum
  always_comb begin
    accept   = en && in_valid && (32'(in_channel) < NUM_CH);
    ch       = in_channel[IDX_W-1:0];
    done     = accept && (cnt[ch] == '1);
    sum_full = acc[ch] + ACC_W'(in_data);
    res_new  = OUT_W'((sum_full + RND) >> S);
    drain    = !out_valid || out_ready;
    take     = drain && gnt_valid;
  end

  // Pending bits: a completion on the channel being drained re-arms it
  always_comb begin
    pend_next = pend;
    if (take) pend_next[gnt_idx] = 1'b0;
    if (done) pend_next[ch] = 1'b1;
  end

  // Per-channel accumulators, counters and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        res[i] <= '0;
      end
    end else if (accept) begin
      if (done) begin
        acc[ch] <= '0;
        cnt[ch] <= '0;
        res[ch] <= res_new;
      end else begin
        acc[ch] <= sum_full;
        cnt[ch] <= cnt[ch] + OSR_LOG2'(1);
      end
    end
  end

  // Output slot, pending bits and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      pend        <= '0;
      rr_ptr      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
    end else begin
      pend <= pend_next;
      if (drain) begin
        if (gnt_valid) begin
          out_valid   <= 1'b1;
          out_data    <= res[gnt_idx];
          out_channel <= CH_W'(gnt_idx);
          rr_ptr      <= (gnt_idx == LAST) ? '0 : gnt_idx + IDX_W'(1);
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef XADC_OVS_OVERRUN_STATUS_EN
  logic [NUM_CH-1:0] ovr_set;

  // Overrun: completion while the previous result is still pending and not leaving
  always_comb begin
    ovr_set = '0;
    if (done && pend[ch] && !(take && gnt_idx == ch)) ovr_set[ch] = 1'b1;
  end

  // Sticky status; a new overrun wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) overrun <= '0;
    else       overrun <= (clr_overrun ? '0 : overrun) | ovr_set;
  end
`else
  // Without status, an overrun simply replaces the pending result.
`endif

endmodule

// File: tb/tb_xadc_oversampler_mc.sv
// Self-checking bench for xadc_oversampler_mc (default parameters).
module tb_xadc_oversampler_mc;

  localparam int NUM_CH     = 4;
  localparam int CH_W       = 5;
  localparam int IN_W       = 12;
  localparam int OSR_LOG2   = 8;
  localparam int EXTRA_BITS = 4;
  localparam int OUT_W      = IN_W + EXTRA_BITS;
  localparam int NSAMP      = 1 << OSR_LOG2;
  localparam int SH         = OSR_LOG2 - EXTRA_BITS;
  localparam int QD         = 16;

  logic              clk = 1'b0;
  logic              reset, en, in_valid, out_valid, out_ready;
  logic [CH_W-1:0]   in_channel, out_channel;
  logic [IN_W-1:0]   in_data;
  logic [OUT_W-1:0]  out_data;
`ifdef XADC_OVS_OVERRUN_STATUS_EN
  logic              clr_overrun;
  logic [NUM_CH-1:0] overrun;
`endif

  xadc_oversampler_mc #(
    .NUM_CH     (NUM_CH),
    .CH_W       (CH_W),
    .IN_W       (IN_W),
    .OSR_LOG2   (OSR_LOG2),
    .EXTRA_BITS (EXTRA_BITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .in_valid    (in_valid),
    .in_channel  (in_channel),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .out_data    (out_data)
`ifdef XADC_OVS_OVERRUN_STATUS_EN
    ,
    .clr_overrun (clr_overrun),
    .overrun     (overrun)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: running sum/count per channel, expected results per channel
  int unsigned m_sum [NUM_CH];
  int          m_cnt [NUM_CH];
  int unsigned exp_mem [NUM_CH][QD];
  int          exp_wr [NUM_CH];
  int          exp_rd [NUM_CH];
  int unsigned last_data [NUM_CH];
  int          seq [$];
  int          n_out = 0;
  int          mc;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sum[c] = 0; m_cnt[c] = 0; exp_wr[c] = 0; exp_rd[c] = 0;
    end
  endtask

  task automatic model_accept(input int ch, input int unsigned data);
    m_sum[ch] += data;
    m_cnt[ch]++;
    if (m_cnt[ch] == NSAMP) begin
      exp_mem[ch][exp_wr[ch] % QD] = (m_sum[ch] + (1 << (SH - 1))) >> SH;
      exp_wr[ch]++;
      m_sum[ch] = 0;
      m_cnt[ch] = 0;
    end
  endtask

  task automatic drive(input bit v, input int ch, input int unsigned data);
    in_valid   = v;
    in_channel = CH_W'(ch);
    in_data    = IN_W'(data);
    if (v && en && ch < NUM_CH) model_accept(ch, data % (1 << IN_W));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send(input int ch, input int unsigned data);
    drive(1'b1, ch, data);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic clear_last();
    for (int c = 0; c < NUM_CH; c++) last_data[c] = 32'hFFFF_FFFF;
  endtask

  // Scoreboard: every handshake must match the oldest expected result of its channel
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      mc = int'(out_channel);
      check("out_ch_range", 32'(mc < NUM_CH), 1);
      if (mc < NUM_CH) begin
        check("sb_expected", 32'(exp_wr[mc] != exp_rd[mc]), 1);
        if (exp_wr[mc] != exp_rd[mc]) begin
          check("sb_data", 32'(out_data), exp_mem[mc][exp_rd[mc] % QD]);
          exp_rd[mc]++;
        end
        last_data[mc] = 32'(out_data);
        seq.push_back(mc);
      end
      n_out++;
    end
  end

  int n0;
  int exp_a [4] = '{3, 0, 1, 2};
  int exp_b [4] = '{1, 2, 3, 0};
  int fin_b [4] = '{1, 0, 2, 3};

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; in_channel = '0; in_data = '0;
    out_ready = 1'b1;
`ifdef XADC_OVS_OVERRUN_STATUS_EN
    clr_overrun = 1'b0;
`endif
    model_clear();
    clear_last();
    tick(); tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_channel", 32'(out_channel), 0);
    reset = 1'b0;

    // Full-scale block on ch0, latency of one edge after the final sample
    for (int i = 0; i < NSAMP; i++) send(0, 12'hFFF);
    check("lat_not_yet", 32'(out_valid), 0);
    tick();
    check("fs_valid", 32'(out_valid), 1);
    check("fs_data", 32'(out_data), 32'hFFF0);
    check("fs_channel", 32'(out_channel), 0);
    tick();
    check("fs_consumed", 32'(out_valid), 0);

    // Interleaved ramp on ch0 and constant on ch1
    clear_last();
    n0 = n_out;
    for (int i = 0; i < NSAMP; i++) begin
      send(0, i);
      send(1, 100);
    end
    repeat (4) tick();
    check("ramp_ch0", last_data[0], 2040);
    check("const_ch1", last_data[1], 1600);
    check("ilv_count", 32'(n_out - n0), 2);

    // Rounding boundary: sum 8 rounds up to 1, sum 7 rounds down to 0
    clear_last();
    n0 = n_out;
    for (int i = 0; i < NSAMP; i++) begin
      send(2, (i == NSAMP - 1) ? 8 : 0);
      send(3, (i == NSAMP - 1) ? 7 : 0);
    end
    repeat (4) tick();
    check("round_up", last_data[2], 1);
    check("round_down", last_data[3], 0);
    check("round_count", 32'(n_out - n0), 2);

    // Dropped samples (bad tag, en low) must not advance the counter
    n0 = n_out;
    for (int i = 0; i < NSAMP - 1; i++) begin
      send(0, $urandom_range(0, 4095));
      send(NUM_CH, $urandom_range(0, 4095));
      en = 1'b0;
      send(0, $urandom_range(0, 4095));
      en = 1'b1;
      if (i % 32 == 0) send(31, 12'hFFF);
    end
    repeat (3) tick();
    check("drop_no_result", 32'(n_out - n0), 0);
    send(0, $urandom_range(0, 4095));
    repeat (3) tick();
    check("drop_one_result", 32'(n_out - n0), 1);

    // Reset mid-block discards the partial sum
    for (int i = 0; i < 100; i++) send(1, $urandom_range(0, 4095));
    do_reset();
    n0 = n_out;
    for (int i = 0; i < NSAMP - 1; i++) send(1, $urandom_range(0, 4095));
    repeat (3) tick();
    check("rst_mid_none", 32'(n_out - n0), 0);
    send(1, $urandom_range(0, 4095));
    repeat (3) tick();
    check("rst_mid_one", 32'(n_out - n0), 1);

    // Overrun: slot held by ch1, ch0 completes twice while stalled
    do_reset();
    clear_last();
    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < NSAMP; i++) send(1, 50);
    for (int i = 0; i < NSAMP; i++) send(0, 10);
    for (int i = 0; i < NSAMP; i++) send(0, 20);
    // the first ch0 result (160) is overwritten and never delivered
    exp_rd[0]++;
    tick();
    check("stall_valid", 32'(out_valid), 1);
    check("stall_channel", 32'(out_channel), 1);
    check("stall_data", 32'(out_data), 800);
`ifdef XADC_OVS_OVERRUN_STATUS_EN
    check("ovr_set", 32'(overrun), 1);
`endif
    out_ready = 1'b1;
    repeat (4) tick();
    check("ovr_count", 32'(n_out - n0), 2);
    check("ovr_ch0_newer", last_data[0], 320);
    check("ovr_ch1", last_data[1], 800);
`ifdef XADC_OVS_OVERRUN_STATUS_EN
    check("ovr_sticky", 32'(overrun), 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);
`endif

    // Round-robin order: burst A from pointer 0, burst B resumes at pointer 3
    do_reset();
    out_ready = 1'b0;
    seq.delete();
    for (int i = 0; i < NSAMP - 1; i++)
      for (int c = 0; c < NUM_CH; c++) send(c, $urandom_range(0, 4095));
    for (int c = NUM_CH - 1; c >= 0; c--) send(c, $urandom_range(0, 4095));
    out_ready = 1'b1;
    repeat (8) tick();
    check("rr_a_count", 32'(seq.size()), 4);
    if (seq.size() == 4)
      for (int k = 0; k < 4; k++) check("rr_a_order", 32'(seq[k]), 32'(exp_a[k]));

    out_ready = 1'b0;
    seq.delete();
    for (int i = 0; i < NSAMP - 1; i++)
      for (int c = 0; c < NUM_CH; c++) send(c, $urandom_range(0, 4095));
    for (int k = 0; k < 4; k++) send(fin_b[k], $urandom_range(0, 4095));
    out_ready = 1'b1;
    repeat (8) tick();
    check("rr_b_count", 32'(seq.size()), 4);
    if (seq.size() == 4)
      for (int k = 0; k < 4; k++) check("rr_b_order", 32'(seq[k]), 32'(exp_b[k]));

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 6000; cyc++) begin
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, NUM_CH + 1), $urandom_range(0, 4095));
    end
    en = 1'b1;
    out_ready = 1'b1;
    repeat (20) tick();
    for (int c = 0; c < NUM_CH; c++) check("final_drained", 32'(exp_wr[c] - exp_rd[c]), 0);
    check("final_idle", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
